fme_transpose_ctrl: RTL and testbench

Sequencing controller that drives the enable and direction inputs of an N×N array of transpose-buffer cells in the FME interpolation path. Sample rows enter the array from upstream on a valid/ready handshake. Transposed columns leave toward the downstream filter stage on a second valid/ready handshake. After the first block fills the array, the write direction flips every N beats, so a block is read out while the next one is written in.

---
 rtl/fme_transpose_ctrl.sv | 146 ++++++++++++++
 tb/tb_fme_transpose_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fme_transpose_ctrl.sv
// Sequencing controller for an NxN transpose-buffer array: fills a block, then streams
// with the shift direction flipping every N beats so one block drains while the next fills.
module fme_transpose_ctrl #(
    parameter int BLOCK_SIZE = 8,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic                 cell_enable,
    output logic                 cell_direction,
    output logic [CNT_WIDTH-1:0] out_index,
    output logic                 out_last
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BLOCK_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   dir_q, dir_d;
    logic                   flush_pend_q, flush_pend_d;

    logic                   flush_hold_s;
    logic                   wrap_s;
    logic                   shift_s;
    logic                   in_ready_s;
    logic                   out_valid_s;

    assign flush_hold_s = flush_pend_q && (cnt_q == CNT_ZERO);
    assign wrap_s       = (cnt_q == CNT_LAST);

    // Per-state shift condition and handshake levels, before reset gating
    always_comb begin
        shift_s     = 1'b0;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                shift_s     = in_valid;
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            ST_STREAM: begin
                shift_s     = in_valid && out_ready && !flush_hold_s;
                in_ready_s  = out_ready && !flush_hold_s;
                out_valid_s = 1'b1;
            end
            ST_DRAIN: begin
                shift_s     = out_ready;
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                shift_s     = 1'b0;
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Next-state logic: counter/direction advance on shifts, mode changes on wrap or pending flush
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        flush_pend_d = flush_pend_q;
        if (shift_s) begin
            if (wrap_s) begin
                cnt_d = CNT_ZERO;
                dir_d = ~dir_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            ST_EMPTY: begin
                if (shift_s && wrap_s) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_STREAM: begin
                // The stalled cnt==0 cycle with a pending flush is the hand-off into DRAIN
                if (flush_hold_s) begin
                    state_d      = ST_DRAIN;
                    flush_pend_d = 1'b0;
                end else if (flush) begin
                    flush_pend_d = 1'b1;
                end else begin
                    flush_pend_d = flush_pend_q;
                end
            end
            ST_DRAIN: begin
                if (shift_s && wrap_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d      = ST_EMPTY;
                cnt_d        = CNT_ZERO;
                dir_d        = 1'b0;
                flush_pend_d = 1'b0;
            end
        endcase
    end

    // Controller state registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_EMPTY;
            cnt_q        <= CNT_ZERO;
            dir_q        <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign in_ready       = reset && in_ready_s;
    assign out_valid      = reset && out_valid_s;
    assign cell_enable    = reset && shift_s;
    assign out_last       = reset && out_valid_s && wrap_s;
    assign cell_direction = dir_q;
    assign out_index      = cnt_q;

endmodule

// File: tb/tb_fme_transpose_ctrl.sv
// Directed bench for fme_transpose_ctrl (N=4) with a row-to-column scoreboard:
// every accepted row queues the column beat it must later produce.
module tb_fme_transpose_ctrl;

    localparam int N = 4;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       flush;
    logic       cell_enable;
    logic       cell_direction;
    logic [1:0] out_index;
    logic       out_last;

    int tests = 0;
    int fails = 0;

    // Scoreboard entry: {last, read direction, index}
    logic [3:0] exp_q[$];
    int         rows_in = 0;
    int         drains  = 0;

    fme_transpose_ctrl #(.BLOCK_SIZE(N), .CNT_WIDTH(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .flush          (flush),
        .cell_enable    (cell_enable),
        .cell_direction (cell_direction),
        .out_index      (out_index),
        .out_last       (out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    // Scoreboard: pop on each consumed column, push on each accepted row
    always @(negedge clock) begin
        logic [3:0] e;
        logic       wd;
        int         idx;
        if (!reset) begin
            exp_q.delete();
            rows_in = 0;
            drains  = 0;
        end else begin
            if (cell_enable && out_valid) begin
                chk1("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chkn("sb_index", out_index, e[1:0]);
                    chk1("sb_dir", cell_direction, e[2]);
                    chk1("sb_last", out_last, e[3]);
                    if (e[3] && exp_q.size() == 0) drains++;
                end
            end
            if (in_valid && in_ready) begin
                idx = rows_in % N;
                wd  = 1'(((rows_in / N) + drains) % 2);
                exp_q.push_back({(idx == N - 1), ~wd, 2'(idx)});
                rows_in++;
            end
        end
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        tick(); tick();
        drive(1'b1, 1'b1, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_cell_enable", cell_enable, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk1("idle_in_ready", in_ready, 1'b1);
        chk1("idle_out_valid", out_valid, 1'b0);
        chkn("idle_index", out_index, 2'd0);
        chk1("idle_dir", cell_direction, 1'b0);
        chk1("idle_enable", cell_enable, 1'b0);

        // Fill latency
        for (int i = 0; i < N; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            chk1("fill_enable", cell_enable, 1'b1);
            chk1("fill_dir", cell_direction, 1'b0);
            chk1("fill_out_valid", out_valid, 1'b0);
            chkn("fill_index", out_index, 2'(i));
            tick();
        end
        drive(1'b0, 1'b1, 1'b0);
        chk1("first_out_valid", out_valid, 1'b1);
        chkn("first_index", out_index, 2'd0);
        chk1("first_dir", cell_direction, 1'b1);
        chk1("no_input_no_shift", cell_enable, 1'b0);

        // Continuous 12-row stream from a fresh reset
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        for (int b = 0; b < 12; b++) begin
            drive(1'b1, 1'b1, 1'b0);
            chk1("stream_enable", cell_enable, 1'b1);
            chk1("stream_in_ready", in_ready, 1'b1);
            chk1("stream_dir", cell_direction, 1'((b / 4) % 2));
            chk1("stream_last", out_last, (b == 7 || b == 11));
            tick();
        end

        // Back-pressure at cnt == 2
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_enable", cell_enable, 1'b0);
            chk1("bp_out_valid", out_valid, 1'b1);
            chkn("bp_index", out_index, 2'd2);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0);
        chkn("bp_resume_index", out_index, 2'd2);
        chk1("bp_resume_enable", cell_enable, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0);
        chkn("bp_after_index", out_index, 2'd3);
        tick();

        // Flush pulse at cnt == 1
        drive(1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1);
        chkn("flush_at_index", out_index, 2'd1);
        chk1("flush_in_ready", in_ready, 1'b1);
        tick();
        for (int k = 2; k < N; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            chk1("flush_cont_in_ready", in_ready, 1'b1);
            chkn("flush_cont_index", out_index, 2'(k));
            tick();
        end
        drive(1'b1, 1'b1, 1'b0);
        chk1("flush_gap_in_ready", in_ready, 1'b0);
        chk1("flush_gap_enable", cell_enable, 1'b0);
        chk1("flush_gap_out_valid", out_valid, 1'b1);
        tick();
        for (int j = 0; j < N; j++) begin
            drive(1'b0, 1'b1, 1'b0);
            chk1("drain_in_ready", in_ready, 1'b0);
            chk1("drain_out_valid", out_valid, 1'b1);
            chk1("drain_enable", cell_enable, 1'b1);
            chkn("drain_index", out_index, 2'(j));
            chk1("drain_last", out_last, (j == N - 1));
            tick();
        end
        drive(1'b0, 1'b1, 1'b0);
        chk1("post_drain_in_ready", in_ready, 1'b1);
        chk1("post_drain_out_valid", out_valid, 1'b0);
        chk1("post_drain_dir", cell_direction, 1'b0);
        chk1("sb_drained", exp_q.size() == 0, 1'b1);

        // Flush in EMPTY after two rows is ignored
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1);
        chk1("empty_flush_out_valid", out_valid, 1'b0);
        chk1("empty_flush_in_ready", in_ready, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0);
        chk1("empty_hold_out_valid", out_valid, 1'b0);
        chkn("empty_hold_index", out_index, 2'd2);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0);
        chk1("refill_out_valid", out_valid, 1'b1);
        chkn("refill_index", out_index, 2'd0);
        chk1("refill_dir", cell_direction, 1'b1);
        chk1("refill_no_pend", in_ready, 1'b1);
        tick();

        // Reset at cnt == 3 mid-STREAM
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick();
        end
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        chk1("mid_rst_in_ready", in_ready, 1'b0);
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk1("mid_rst_enable", cell_enable, 1'b0);
        chk1("mid_rst_out_last", out_last, 1'b0);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        chk1("after_rst_out_valid", out_valid, 1'b0);
        chkn("after_rst_index", out_index, 2'd0);
        chk1("after_rst_dir", cell_direction, 1'b0);
        chk1("after_rst_in_ready", in_ready, 1'b1);
        for (int i = 0; i < N; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            chk1("rst_refill_out_valid", out_valid, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0);
        chk1("rst_refill_done", out_valid, 1'b1);
        chkn("rst_refill_index", out_index, 2'd0);
        chk1("rst_refill_dir", cell_direction, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
